// File: rtl/program_loader.sv
// UART-fed instruction-memory loader: receives a big-endian word count followed by
// 16-bit words (hi byte first), writes them from address 0, then releases the CPU reset.
module program_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              RXD,
  output logic              IM_WE,
  output logic [ADDR_W-1:0] IM_ADDR,
  output logic [DATA_W-1:0] IM_WDATA,
  output logic              CPU_RST_N,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);
  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF      = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LEN_HI, LEN_LO, W_HI, W_LO, WRITE, FINISH, FAULT} ld_state_t;

  rx_state_t        rx_state, rx_nxt;
  ld_state_t        ld_state, ld_nxt;
  logic             rxd_m, rxd_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       rx_shift;
  logic             rx_tick, byte_vld, frame_err;
  logic [7:0]       len_hi, w_hi;
  logic [16:0]      len_n, remain;

  // RXD is asynchronous; idle level is high so the synchronizer resets to 1
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= RXD;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) rx_state <= RX_IDLE;
    else        rx_state <= rx_nxt;
  end

  always_comb begin
    rx_nxt    = rx_state;
    rx_tick   = 1'b0;
    byte_vld  = 1'b0;
    frame_err = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rxd_s) rx_nxt = RX_START;
      RX_START: if (clk_cnt == HALF) begin
        rx_tick = 1'b1;
        rx_nxt  = rxd_s ? RX_IDLE : RX_DATA;  // high mid-start-bit: glitch, not an error
      end
      RX_DATA:  if (clk_cnt == FULL) begin
        rx_tick = 1'b1;
        if (bit_cnt == 3'd7) rx_nxt = RX_STOP;
      end
      RX_STOP:  if (clk_cnt == FULL) begin
        rx_tick   = 1'b1;
        rx_nxt    = RX_IDLE;
        byte_vld  = rxd_s;
        frame_err = !rxd_s;
      end
      default:  rx_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == RX_IDLE || rx_tick) clk_cnt <= '0;
      else                                clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_IDLE) begin
        bit_cnt <= '0;
      end else if (rx_state == RX_DATA && rx_tick) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= {rxd_s, rx_shift[7:1]};
      end
    end
  end

  assign len_n = {1'b0, len_hi, rx_shift};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ld_state <= LEN_HI;
    else        ld_state <= ld_nxt;
  end

  always_comb begin
    ld_nxt = ld_state;
    if (frame_err && ld_state != FINISH && ld_state != FAULT) begin
      ld_nxt = FAULT;
    end else begin
      case (ld_state)
        LEN_HI: if (byte_vld) ld_nxt = LEN_LO;
        LEN_LO: if (byte_vld) begin
          if (len_n == '0)            ld_nxt = FINISH;
          else if (len_n > MAX_WORDS) ld_nxt = FAULT;
          else                        ld_nxt = W_HI;
        end
        W_HI:   if (byte_vld) ld_nxt = W_LO;
        W_LO:   if (byte_vld) ld_nxt = WRITE;
        WRITE:  ld_nxt = (remain == 17'd1) ? FINISH : W_HI;
        default: ld_nxt = ld_state;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      IM_WE     <= 1'b0;
      IM_ADDR   <= '0;
      IM_WDATA  <= '0;
      CPU_RST_N <= 1'b0;
      BUSY      <= 1'b1;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      len_hi    <= '0;
      w_hi      <= '0;
      remain    <= '0;
    end else begin
      IM_WE     <= (ld_nxt == WRITE);
      CPU_RST_N <= (ld_nxt == FINISH);
      DONE      <= (ld_nxt == FINISH);
      ERR       <= (ld_nxt == FAULT);
      BUSY      <= !(ld_nxt == FINISH || ld_nxt == FAULT);
      if (ld_state == LEN_HI && byte_vld) len_hi <= rx_shift;
      if (ld_state == LEN_LO && byte_vld) remain <= len_n;
      if (ld_state == W_HI && byte_vld)   w_hi   <= rx_shift;
      if (ld_state == W_LO && ld_nxt == WRITE) IM_WDATA <= DATA_W'({w_hi, rx_shift});
      if (ld_state == WRITE) begin
        IM_ADDR <= IM_ADDR + 1'b1;
        remain  <= remain - 1'b1;
      end
    end
  end
endmodule
